// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the bit-serial unsigned magnitude comparator.
package serial_mag_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_mag_comparator_cmp_bit_cell.sv
// Single-bit decision cell: the first differing pair (MSB first) decides the comparison.
module cmp_bit_cell
  import serial_mag_comparator_pkg::*;
(
  input  logic a_bit,
  input  logic b_bit,
  input  logic decided_in,
  output logic decided_out,
  output logic gt_out,
  output logic lt_out
);

  assign decided_out = decided_in | (a_bit ^ b_bit);
  assign gt_out      = ~decided_in & a_bit & ~b_bit;
  assign lt_out      = ~decided_in & ~a_bit & b_bit;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: consumes WIDTH a/b pairs MSB first, reports eq/gt/lt.
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic eq,
  output logic gt,
  output logic lt,
  output logic result_valid
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          decided_q;
  logic          eq_q;
  logic          gt_q;
  logic          lt_q;
  logic          rv_q;

  logic          consume;
  logic          last_pair;
  logic          dec_nxt;
  logic          gt_nxt;
  logic          lt_nxt;

  assign consume   = (state_q == SHIFT) && bit_valid;
  assign last_pair = (cnt_q == CW'(WIDTH - 1));

  cmp_bit_cell u_cell (
    .a_bit       (a_bit),
    .b_bit       (b_bit),
    .decided_in  (decided_q),
    .decided_out (dec_nxt),
    .gt_out      (gt_nxt),
    .lt_out      (lt_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (consume && last_pair) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: counter, decision flag and latched result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      decided_q <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            decided_q <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            rv_q      <= 1'b0;
          end
        end
        SHIFT: begin
          if (consume) begin
            cnt_q     <= cnt_q + CW'(1);
            decided_q <= dec_nxt;
            gt_q      <= gt_q | gt_nxt;
            lt_q      <= lt_q | lt_nxt;
            // eq is only resolved once the final pair has had its say
            if (last_pair) begin
              eq_q <= ~dec_nxt;
              rv_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bit_ready    = (state_q == SHIFT);
  assign busy         = (state_q == SHIFT) || (state_q == DONE);
  assign done         = (state_q == DONE);
  assign eq           = eq_q;
  assign gt           = gt_q;
  assign lt           = lt_q;
  assign result_valid = rv_q;

endmodule
